// File: rtl/pc_sequencer_if.sv
// Purpose : bundles the request, mux-feedback and status signals of the PC sequencer.
// Latency : none (wiring only).
// Backpressure: stall travels on this bundle; the sequencer holds PC while it is high.
//
// Ports (master = core/mux side, slave = sequencer):
//   stall, jump, jump_target, branch_taken, branch_target, halt_req, next_pc : master -> slave
//   pc, pc_plus, redirect_target, jump_sel, flush, pc_valid, halted, redirect_count : slave -> master
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            halt_req;
    logic [PC_W-1:0] next_pc;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus;
    logic [PC_W-1:0] redirect_target;
    logic            jump_sel;
    logic            flush;
    logic            pc_valid;
    logic            halted;
    logic [7:0]      redirect_count;

    modport master (
        output stall, jump, jump_target, branch_taken, branch_target, halt_req, next_pc,
        input  pc, pc_plus, redirect_target, jump_sel, flush, pc_valid, halted, redirect_count
    );

    modport slave (
        input  stall, jump, jump_target, branch_taken, branch_target, halt_req, next_pc,
        output pc, pc_plus, redirect_target, jump_sel, flush, pc_valid, halted, redirect_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose : owns the program counter, drives the external 2:1 PC-mux select and registers its output.
// Latency : redirect requested in cycle N -> pc = target and flush = 1 in N+1; sequential again in N+2.
// Backpressure: stall holds pc and blocks redirects/halt; in FLUSH it holds flush high.
//
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   seq_if      : pc_sequencer_if.slave (requests and mux feedback in, pc/select/status out)
// Optional build macro: SELF_JUMP_HALT_EN -- a jump to the current pc in RUN halts instead of redirecting.
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  seq_if
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            jump_sel;
    logic            self_jump;

    // A jump onto the instruction currently being fetched is an infinite loop;
    // the optional build turns it into a halt.
`ifdef SELF_JUMP_HALT_EN
    assign self_jump = seq_if.jump && (seq_if.jump_target == pc_q);
`else
    assign self_jump = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        cnt_d    = cnt_q;
        jump_sel = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // Halt outranks redirects but, like them, waits for stall to drop.
                if ((seq_if.halt_req || self_jump) && !seq_if.stall) begin
                    state_d = HALT;
                end else if (seq_if.stall) begin
                    pc_d = pc_q;
                end else if (seq_if.jump || seq_if.branch_taken) begin
                    jump_sel = 1'b1;
                    pc_d     = seq_if.next_pc;
                    flush_d  = 1'b1;
                    state_d  = FLUSH;
                    cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else begin
                    // Mux select is 0 here, so next_pc carries pc_plus.
                    pc_d = seq_if.next_pc;
                end
            end
            FLUSH: begin
                // Requests arriving now belong to the squashed instruction.
                if (seq_if.stall) begin
                    flush_d = 1'b1;
                end else begin
                    pc_d    = seq_if.next_pc;
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign seq_if.pc              = pc_q;
    assign seq_if.pc_plus         = pc_q + PC_W'(PC_INC);
    assign seq_if.redirect_target = seq_if.jump ? seq_if.jump_target : seq_if.branch_target;
    assign seq_if.jump_sel        = jump_sel;
    assign seq_if.flush           = flush_q;
    assign seq_if.pc_valid        = (state_q == RUN) || (state_q == FLUSH);
    assign seq_if.halted          = (state_q == HALT);
    assign seq_if.redirect_count  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : randomized + directed scoreboard bench for pc_sequencer with the PC mux modelled externally.
// Latency : expectations are queued per cycle at stimulus time and popped by an independent monitor.
// Backpressure: stall is exercised both in directed sequences and randomly.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.PC_W(8)) bus ();

    pc_sequencer #(.PC_W(8), .RESET_PC(8'h00), .PC_INC(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    // External 2:1 PC mux.
    assign bus.next_pc = bus.jump_sel ? bus.redirect_target : bus.pc_plus;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] pc_plus;
        logic [7:0] rt;
        logic       js;
        logic       fl;
        logic       pv;
        logic       hl;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: mode name, current pc and redirect tally.
    localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;
    int m_mode;
    int m_pc;
    int m_cnt;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",              bus.pc,                      e.pc);
                chk("pc_plus",         bus.pc_plus,                 e.pc_plus);
                chk("redirect_target", bus.redirect_target,         e.rt);
                chk("jump_sel",        {7'd0, bus.jump_sel},        {7'd0, e.js});
                chk("flush",           {7'd0, bus.flush},           {7'd0, e.fl});
                chk("pc_valid",        {7'd0, bus.pc_valid},        {7'd0, e.pv});
                chk("halted",          {7'd0, bus.halted},          {7'd0, e.hl});
                chk("redirect_count",  bus.redirect_count,          e.cnt);
            end
        end
    end

    task automatic drive(input bit st, input bit j, input logic [7:0] jt,
                         input bit br, input logic [7:0] bt, input bit h);
        bus.stall         = st;
        bus.jump          = j;
        bus.jump_target   = jt;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.halt_req      = h;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        m_mode = M_BOOT;
        m_pc   = 0;
        m_cnt  = 0;
        e.pc = 8'h00; e.pc_plus = 8'h01; e.rt = 8'h00;
        e.js = 0; e.fl = 0; e.pv = 0; e.hl = 0; e.cnt = 8'h00;
        q.push_back(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle of stimulus: drive, queue what the DUT must show, advance the model.
    task automatic step(input bit st, input bit j, input logic [7:0] jt,
                        input bit br, input logic [7:0] bt, input bit h);
        exp_t e;
        bit   sj;
        bit   redir;
        @(negedge clk);
        drive(st, j, jt, br, bt, h);
        sj = 1'b0;
`ifdef SELF_JUMP_HALT_EN
        sj = j && (int'(jt) == m_pc);
`endif
        redir = (m_mode == M_RUN) && !st && !h && !sj && (j || br);
        e.pc      = 8'(m_pc);
        e.pc_plus = 8'((m_pc + 1) % 256);
        e.rt      = j ? jt : bt;
        e.js      = redir;
        e.fl      = (m_mode == M_FLUSH);
        e.pv      = (m_mode == M_RUN) || (m_mode == M_FLUSH);
        e.hl      = (m_mode == M_HALT);
        e.cnt     = 8'(m_cnt);
        q.push_back(e);
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if ((h || sj) && !st) begin
                    m_mode = M_HALT;
                end else if (redir) begin
                    m_pc   = j ? int'(jt) : int'(bt);
                    m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_mode = M_FLUSH;
                end else if (!st) begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
            M_FLUSH: begin
                if (!st) begin
                    m_pc   = (m_pc + 1) % 256;
                    m_mode = M_RUN;
                end
            end
            default: ;
        endcase
    endtask

    task automatic idle() ;
        step(0, 0, 8'h00, 0, 8'h00, 0);
    endtask

    // Run sequentially until the model pc reaches target; an expired budget is a failure.
    task automatic idle_until(input int target);
        int n;
        n = 0;
        while (m_pc != target && n < 300) begin
            idle();
            n++;
        end
        checks++;
        if (m_pc != target) begin
            errors++;
            $display("FAIL reach_pc: got %02h expected %02h (cycle budget expired)", m_pc, target);
        end
    endtask

    initial begin
        logic [7:0] jt;
        logic [7:0] bt;
        bit st, j, br, h;
        int r;

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        m_mode = M_BOOT; m_pc = 0; m_cnt = 0;

        // Reset release, sequential stepping, then a jump from 0x05 to 0x40.
        do_reset();
        idle_until(5);
        step(0, 1, 8'h40, 0, 8'h00, 0);
        idle();
        idle();

        // Jump and taken branch together: the jump target wins, one count.
        step(0, 1, 8'h20, 1, 8'h30, 0);
        idle();
        idle();

        // Branch alone.
        step(0, 0, 8'h00, 1, 8'h08, 0);
        idle();

        // Stall holds a pending jump at 0x10 for three cycles.
        step(0, 1, 8'h0C, 0, 8'h00, 0);
        idle_until(8'h10);
        repeat (3) step(1, 1, 8'h80, 0, 8'h00, 0);
        step(0, 1, 8'h80, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0, 8'h00, 0);
        idle();
        idle();

        // Wrap 0xFF -> 0x00, then halt for ten cycles of noisy requests, then reset.
        step(0, 1, 8'hFC, 0, 8'h00, 0);
        idle_until(8'h01);
        step(1, 0, 8'h00, 0, 8'h00, 1);
        step(0, 1, 8'h55, 1, 8'h66, 1);
        repeat (10) begin
            jt = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), jt,
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        do_reset();
        idle();
        idle();
        idle();

        // Self-jump at 0x33.
        step(0, 1, 8'h32, 0, 8'h00, 0);
        idle_until(8'h33);
        repeat (6) step(0, 1, 8'h33, 0, 8'h00, 0);
        do_reset();

        // Continuous redirects push the counter into saturation.
        repeat (600) begin
            jt = 8'((m_pc + 7) % 256);
            step(0, 1, jt, 0, 8'h00, 0);
        end
        idle();
        do_reset();

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 3) == 0);
                j  = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 3) == 0);
                h  = ($urandom_range(0, 59) == 0);
                jt = ($urandom_range(0, 7) == 0) ? 8'(m_pc) : 8'($urandom_range(0, 255));
                bt = 8'($urandom_range(0, 255));
                step(st, j, jt, br, bt, h);
            end
        end

        // Let the monitor drain, then confirm nothing was left unchecked.
        @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
